// File: rtl/psum_router_pkg.sv
// Shared definitions for the PE psum routers: mode tags, FSM encoding, bus-ID helper.
package psum_router_pkg;

  localparam logic MODE_BUS   = 1'b0;
  localparam logic MODE_CHAIN = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Bus ID lives above the chain tag bit; callers zero-extend into 32 bits.
  function automatic logic [31:0] bus_id_of(input logic [31:0] id);
    return {1'b0, id[31:1]};
  endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Small bus-path psum buffer; flush empties it and wins over push/pop.
module psum_out_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  do_push, do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers are AW bits wide, so wrap is implicit for a power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/psum_out_router.sv
// Steers one PE's psum stream to the next PE in the chain or, via a FIFO, to the shared bus.
module psum_out_router
  import psum_router_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int CNT_WIDTH  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  config_state,
  input  logic                  ce,
  input  logic [ID_WIDTH-1:0]   dest_id,
  input  logic [CNT_WIDTH-1:0]  psum_num,
  input  logic [DATA_WIDTH-1:0] pe_psum_out,
  input  logic                  pe_psum_out_valid,
  output logic                  pe_psum_out_ready,
  output logic [DATA_WIDTH-1:0] next_pe_data_out,
  output logic                  next_pe_data_valid,
  input  logic [ID_WIDTH-1:0]   bus_grant_id,
  input  logic                  bus_ready,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  output logic                  bus_data_valid,
  output logic                  psum_out_done,
  output logic                  router_busy
);

  logic [ID_WIDTH-1:0]  stored_id;
  logic [CNT_WIDTH-1:0] stored_num, sent_cnt, sent_nxt;
  state_t               state;
  logic                 cfg, mode, grant_match;
  logic                 fifo_full, fifo_empty;
  logic                 accept, push, pop, deliver, last;

  assign cfg         = config_state && ce;
  assign mode        = stored_id[0];
  assign grant_match = (32'(bus_grant_id) == bus_id_of(32'(stored_id)));

  assign pe_psum_out_ready = (mode == MODE_CHAIN) ? 1'b1 : !fifo_full;
  // Config owns the cycle: nothing is accepted, pushed or popped alongside it.
  assign accept         = pe_psum_out_valid && pe_psum_out_ready && !cfg;
  assign push           = accept && (mode == MODE_BUS);
  assign bus_data_valid = (mode == MODE_BUS) && !fifo_empty && grant_match;
  assign pop            = bus_data_valid && bus_ready && !cfg;
  assign deliver        = (accept && (mode == MODE_CHAIN)) || pop;
  assign sent_nxt       = sent_cnt + 1'b1;
  assign last           = (stored_num != '0) && (sent_nxt == stored_num);
  assign router_busy    = (state == ST_SEND) || !fifo_empty;

  psum_out_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (cfg),
    .din   (pe_psum_out),
    .dout  (bus_data_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stored_id  <= '0;
      stored_num <= '0;
    end else if (cfg) begin
      stored_id  <= dest_id;
      stored_num <= psum_num;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pe_data_out   <= '0;
      next_pe_data_valid <= 1'b0;
    end else begin
      next_pe_data_valid <= accept && (mode == MODE_CHAIN);
      if (accept && (mode == MODE_CHAIN)) next_pe_data_out <= pe_psum_out;
    end
  end

  // Deliveries count in either state so a psum arriving right after done starts a new run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sent_cnt      <= '0;
      psum_out_done <= 1'b0;
    end else if (cfg) begin
      state         <= ST_IDLE;
      sent_cnt      <= '0;
      psum_out_done <= 1'b0;
    end else begin
      psum_out_done <= 1'b0;
      if (deliver) begin
        if (last) begin
          psum_out_done <= 1'b1;
          sent_cnt      <= '0;
          state         <= ST_IDLE;
        end else begin
          sent_cnt <= sent_nxt;
          state    <= ST_SEND;
        end
      end else if (accept && state == ST_IDLE) begin
        state <= ST_SEND;
      end
    end
  end

endmodule
